// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the EX stage and its multiply/divide unit.
//   md_op_e    : W_ID_md_op encodings (NONE/MULT/MULTU/DIV/DIVU/MFHI/MFLO)
//   fwd_sel_e  : operand forward-select codes
//   alu_op_e   : W_ID_alu_sel encodings for the single-cycle ALU
//   md_state_e : iterative multiply/divide sequencer states
package ex_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_REG    = 2'b00,
        FWD_EX_MEM = 2'b01,
        FWD_WB     = 2'b10,
        FWD_ZERO   = 2'b11
    } fwd_sel_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // True for the md_op codes that launch an iterative operation.
    function automatic logic is_md_start(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: iterative radix-2 multiply / restoring divide, DATA_W cycles per op.
//   clk, rst      : clock, asynchronous active-high reset (aborts any op)
//   start         : launch an op (sampled only when idle)
//   is_signed     : operands are two's complement
//   op_div        : 1 = divide, 0 = multiply
//   a, b          : multiplicand/multiplier or dividend/divisor
//   busy          : op in flight (cycle after start through the last edge)
//   done          : one-cycle pulse after HI/LO update
//   hi, lo        : result registers
module md_unit
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic              op_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    md_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   acc;   // product high half / partial remainder
    logic [DATA_W-1:0] qr;    // multiplier / dividend shifting into quotient
    logic [DATA_W-1:0] dv;    // multiplicand / divisor magnitude
    logic              neg_q; // result (product or quotient) is negative
    logic              neg_r; // remainder takes dividend's sign
    logic              div_zero;

    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    logic [DATA_W:0]     mul_sum, mul_acc_n;
    logic [DATA_W-1:0]   mul_qr_n;
    logic [2*DATA_W-1:0] prod, prod_s;

    logic [DATA_W:0]     div_shift, div_acc_n;
    logic                div_ge;
    logic [DATA_W-1:0]   div_qr_n, quot, rem;

    // Both ops run on magnitudes; signs are re-applied on the last edge.
    always_comb begin
        a_neg = is_signed & a[DATA_W-1];
        b_neg = is_signed & b[DATA_W-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[DATA_W-1:0]} + {1'b0, (qr[0] ? dv : '0)};
        mul_acc_n = {1'b0, mul_sum[DATA_W:1]};
        mul_qr_n  = {mul_sum[0], qr[DATA_W-1:1]};
        prod      = {mul_acc_n[DATA_W-1:0], mul_qr_n};
        prod_s    = neg_q ? (~prod + 1'b1) : prod;

        div_shift = {acc[DATA_W-1:0], qr[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, dv});
        div_acc_n = div_ge ? (div_shift - {1'b0, dv}) : div_shift;
        div_qr_n  = {qr[DATA_W-2:0], div_ge};
        quot      = neg_q ? (~div_qr_n + 1'b1) : div_qr_n;
        // With a zero divisor every step subtracts nothing, so the remainder
        // ends up holding the dividend magnitude; only LO needs forcing.
        rem       = neg_r ? (~div_acc_n[DATA_W-1:0] + 1'b1) : div_acc_n[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            qr       <= '0;
            dv       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        qr       <= a_mag;
                        dv       <= b_mag;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (b == '0);
                        cnt      <= CNT_W'(DATA_W);
                        busy     <= 1'b1;
                        state    <= op_div ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc <= mul_acc_n;
                    qr  <= mul_qr_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        hi    <= prod_s[2*DATA_W-1:DATA_W];
                        lo    <= prod_s[DATA_W-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    acc <= div_acc_n;
                    qr  <= div_qr_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        hi    <= rem;
                        lo    <= div_zero ? '1 : quot;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_md_stage.sv
// ex_md_stage: execute stage with forwarding, single-cycle ALU and an
// iterative multiply/divide unit holding HI/LO.
//   clk, rst                  : clock, asynchronous active-high reset
//   W_ID_*                    : decoded instruction from ID (operands, imm,
//                               alu/md op, forward codes, passthrough controls)
//   W_forwardA/B              : 00 reg, 01 EX/MEM result, 10 WB data, 11 zero
//   W_EX_MEM_alu_res, W_WB_wb_data : forwarded values
//   W_EX_*                    : combinational EX results / controls
//   W_EX_stall                : hold upstream while md unit is busy
//   W_EX_md_busy              : multiply/divide in flight
module ex_md_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              W_ID_valid,
    input  logic [DATA_W-1:0] W_ID_rs_data,
    input  logic [DATA_W-1:0] W_ID_rt_data,
    input  logic              W_ID_rt_sel,
    input  logic              W_ID_imm_sext,
    input  logic [IMM_W-1:0]  W_ID_imme,
    input  logic [3:0]        W_ID_alu_sel,
    input  logic [2:0]        W_ID_md_op,
    input  logic [1:0]        W_forwardA,
    input  logic [1:0]        W_forwardB,
    input  logic [DATA_W-1:0] W_EX_MEM_alu_res,
    input  logic [DATA_W-1:0] W_WB_wb_data,
    input  logic [4:0]        W_ID_rd,
    input  logic              W_ID_w_mem_ena,
    input  logic              W_ID_w_reg_ena,
    input  logic              W_ID_wb_sel,
    output logic [DATA_W-1:0] W_EX_alu_res,
    output logic [DATA_W-1:0] W_EX_rt_data,
    output logic [4:0]        W_EX_rd,
    output logic              W_EX_w_mem_ena,
    output logic              W_EX_w_reg_ena,
    output logic              W_EX_wb_sel,
    output logic              W_EX_valid,
    output logic              W_EX_stall,
    output logic              W_EX_md_busy
);

    localparam int SH_W = $clog2(DATA_W);

    md_op_e            md_op;
    logic [DATA_W-1:0] fwd_a, fwd_b, op_b, imm_ext, alu_res;
    logic [SH_W-1:0]   shamt;
    logic              md_busy, md_start, md_done_unused;
    logic [DATA_W-1:0] md_hi, md_lo;

    assign md_op = md_op_e'(W_ID_md_op);

    always_comb begin
        case (fwd_sel_e'(W_forwardA))
            FWD_REG:    fwd_a = W_ID_rs_data;
            FWD_EX_MEM: fwd_a = W_EX_MEM_alu_res;
            FWD_WB:     fwd_a = W_WB_wb_data;
            default:    fwd_a = '0;
        endcase
        case (fwd_sel_e'(W_forwardB))
            FWD_REG:    fwd_b = W_ID_rt_data;
            FWD_EX_MEM: fwd_b = W_EX_MEM_alu_res;
            FWD_WB:     fwd_b = W_WB_wb_data;
            default:    fwd_b = '0;
        endcase
    end

    assign imm_ext = W_ID_imm_sext ? {{(DATA_W-IMM_W){W_ID_imme[IMM_W-1]}}, W_ID_imme}
                                   : {{(DATA_W-IMM_W){1'b0}}, W_ID_imme};
    assign op_b    = W_ID_rt_sel ? imm_ext : fwd_b;
    assign shamt   = op_b[SH_W-1:0];

    always_comb begin
        case (alu_op_e'(W_ID_alu_sel))
            ALU_ADD:  alu_res = fwd_a + op_b;
            ALU_SUB:  alu_res = fwd_a - op_b;
            ALU_AND:  alu_res = fwd_a & op_b;
            ALU_OR:   alu_res = fwd_a | op_b;
            ALU_XOR:  alu_res = fwd_a ^ op_b;
            ALU_NOR:  alu_res = ~(fwd_a | op_b);
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (fwd_a < op_b)};
            ALU_SLL:  alu_res = fwd_a << shamt;
            ALU_SRL:  alu_res = fwd_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(fwd_a) >>> shamt);
            ALU_LUI:  alu_res = op_b << (DATA_W / 2);
            default:  alu_res = '0;
        endcase
    end

    // Any md instruction (start or HI/LO read) waits for the unit; ALU ops don't.
    assign W_EX_stall = W_ID_valid & md_busy & (md_op != MD_NONE);
    assign md_start   = W_ID_valid & is_md_start(md_op) & ~W_EX_stall;

    md_unit #(
        .DATA_W (DATA_W)
    ) u_md_unit (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .is_signed ((md_op == MD_MULT) || (md_op == MD_DIV)),
        .op_div    ((md_op == MD_DIV) || (md_op == MD_DIVU)),
        .a         (fwd_a),
        .b         (fwd_b),
        .busy      (md_busy),
        .done      (md_done_unused),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_comb begin
        case (md_op)
            MD_MFHI: W_EX_alu_res = md_hi;
            MD_MFLO: W_EX_alu_res = md_lo;
            default: W_EX_alu_res = alu_res;
        endcase
    end

    assign W_EX_rt_data   = fwd_b;
    assign W_EX_rd        = W_ID_rd;
    assign W_EX_wb_sel    = W_ID_wb_sel;
    assign W_EX_valid     = W_ID_valid & ~W_EX_stall;
    assign W_EX_w_mem_ena = W_ID_w_mem_ena & ~W_EX_stall;
    assign W_EX_w_reg_ena = W_ID_w_reg_ena & ~W_EX_stall;
    assign W_EX_md_busy   = md_busy;

endmodule

// File: tb/tb_ex_md_stage.sv
module tb_ex_md_stage;
    import ex_pkg::*;

    localparam int DW = 32;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          W_ID_valid;
    logic [DW-1:0] W_ID_rs_data, W_ID_rt_data;
    logic          W_ID_rt_sel, W_ID_imm_sext;
    logic [IW-1:0] W_ID_imme;
    logic [3:0]    W_ID_alu_sel;
    logic [2:0]    W_ID_md_op;
    logic [1:0]    W_forwardA, W_forwardB;
    logic [DW-1:0] W_EX_MEM_alu_res, W_WB_wb_data;
    logic [4:0]    W_ID_rd;
    logic          W_ID_w_mem_ena, W_ID_w_reg_ena, W_ID_wb_sel;
    logic [DW-1:0] W_EX_alu_res, W_EX_rt_data;
    logic [4:0]    W_EX_rd;
    logic          W_EX_w_mem_ena, W_EX_w_reg_ena, W_EX_wb_sel, W_EX_valid;
    logic          W_EX_stall, W_EX_md_busy;

    always #5 clk = ~clk;

    ex_md_stage #(
        .DATA_W (DW),
        .IMM_W  (IW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .W_ID_valid       (W_ID_valid),
        .W_ID_rs_data     (W_ID_rs_data),
        .W_ID_rt_data     (W_ID_rt_data),
        .W_ID_rt_sel      (W_ID_rt_sel),
        .W_ID_imm_sext    (W_ID_imm_sext),
        .W_ID_imme        (W_ID_imme),
        .W_ID_alu_sel     (W_ID_alu_sel),
        .W_ID_md_op       (W_ID_md_op),
        .W_forwardA       (W_forwardA),
        .W_forwardB       (W_forwardB),
        .W_EX_MEM_alu_res (W_EX_MEM_alu_res),
        .W_WB_wb_data     (W_WB_wb_data),
        .W_ID_rd          (W_ID_rd),
        .W_ID_w_mem_ena   (W_ID_w_mem_ena),
        .W_ID_w_reg_ena   (W_ID_w_reg_ena),
        .W_ID_wb_sel      (W_ID_wb_sel),
        .W_EX_alu_res     (W_EX_alu_res),
        .W_EX_rt_data     (W_EX_rt_data),
        .W_EX_rd          (W_EX_rd),
        .W_EX_w_mem_ena   (W_EX_w_mem_ena),
        .W_EX_w_reg_ena   (W_EX_w_reg_ena),
        .W_EX_wb_sel      (W_EX_wb_sel),
        .W_EX_valid       (W_EX_valid),
        .W_EX_stall       (W_EX_stall),
        .W_EX_md_busy     (W_EX_md_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: the driver pushes expectations for the current cycle,
    // the negedge monitor pops and compares them against the DUT.
    typedef enum int {F_ALU, F_RT, F_RD, F_VALID, F_WREG, F_WMEM, F_WBSEL, F_STALL, F_BUSY} fld_e;
    typedef struct {
        string       tag;
        fld_e        fld;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic expect_val(input string tag, input fld_e f, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.fld)
                F_ALU:   act = 64'(W_EX_alu_res);
                F_RT:    act = 64'(W_EX_rt_data);
                F_RD:    act = 64'(W_EX_rd);
                F_VALID: act = 64'(W_EX_valid);
                F_WREG:  act = 64'(W_EX_w_reg_ena);
                F_WMEM:  act = 64'(W_EX_w_mem_ena);
                F_WBSEL: act = 64'(W_EX_wb_sel);
                F_STALL: act = 64'(W_EX_stall);
                default: act = 64'(W_EX_md_busy);
            endcase
            check_eq(e.tag, act, e.val);
        end
    end

    // Reference state: HI/LO and remaining busy cycles of the md unit.
    logic [DW-1:0] m_hi = '0, m_lo = '0;
    int            md_left = 0;
    bit            start_pend = 1'b0;

    task automatic tick();
        @(posedge clk);
        if (md_left > 0) md_left--;
        if (start_pend) begin
            md_left    = DW;
            start_pend = 1'b0;
        end
        #1;
    endtask

    function automatic logic [DW-1:0] alu_ref(input logic [3:0] sel, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic signed [DW-1:0] sa, sb_;
        sa  = a;
        sb_ = b;
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return (sa < sb_) ? 32'd1 : 32'd0;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return sa >>> b[4:0];
            4'd11:   return {b[15:0], 16'h0};
            default: return '0;
        endcase
    endfunction

    task automatic md_model(input md_op_e op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sbv;
        sa  = a;
        sbv = b;
        case (op)
            MD_MULT: begin
                sp = 64'(sa) * 64'(sbv);
                {m_hi, m_lo} = sp;
            end
            MD_MULTU: {m_hi, m_lo} = {32'h0, a} * {32'h0, b};
            MD_DIV: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a;
                    m_hi = 0;
                end else begin
                    m_lo = sa / sbv;
                    m_hi = sa % sbv;
                end
            end
            default: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
        endcase
    endtask

    task automatic set_idle();
        W_ID_valid = 0; W_ID_rs_data = '0; W_ID_rt_data = '0; W_ID_rt_sel = 0;
        W_ID_imm_sext = 0; W_ID_imme = '0; W_ID_alu_sel = '0; W_ID_md_op = MD_NONE;
        W_forwardA = FWD_REG; W_forwardB = FWD_REG; W_EX_MEM_alu_res = '0;
        W_WB_wb_data = '0; W_ID_rd = '0; W_ID_w_mem_ena = 0; W_ID_w_reg_ena = 0;
        W_ID_wb_sel = 0;
    endtask

    task automatic idle_cycle(input string tag);
        set_idle();
        expect_val({tag, "_busy"}, F_BUSY, 64'(md_left > 0));
        expect_val({tag, "_valid"}, F_VALID, 0);
        tick();
    endtask

    task automatic alu_instr(input string tag, input logic [3:0] sel,
                             input logic [DW-1:0] a, input logic [DW-1:0] b);
        set_idle();
        W_ID_valid = 1; W_ID_alu_sel = sel; W_ID_rs_data = a; W_ID_rt_data = b;
        W_ID_rd = 5'($urandom_range(0, 31)); W_ID_wb_sel = 1'($urandom_range(0, 1));
        W_ID_w_reg_ena = 1; W_ID_w_mem_ena = 1;
        expect_val({tag, "_res"}, F_ALU, 64'(alu_ref(sel, a, b)));
        expect_val({tag, "_rt"}, F_RT, 64'(b));
        expect_val({tag, "_rd"}, F_RD, 64'(W_ID_rd));
        expect_val({tag, "_wbsel"}, F_WBSEL, 64'(W_ID_wb_sel));
        expect_val({tag, "_stall"}, F_STALL, 0);
        expect_val({tag, "_valid"}, F_VALID, 1);
        expect_val({tag, "_wreg"}, F_WREG, 1);
        expect_val({tag, "_wmem"}, F_WMEM, 1);
        expect_val({tag, "_busy"}, F_BUSY, 64'(md_left > 0));
        tick();
    endtask

    task automatic md_start(input string tag, input md_op_e op,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        set_idle();
        W_ID_valid = 1; W_ID_md_op = op; W_ID_rs_data = a; W_ID_rt_data = b;
        expect_val({tag, "_stall"}, F_STALL, 0);
        expect_val({tag, "_busy0"}, F_BUSY, 0);
        md_model(op, a, b);
        start_pend = 1'b1;
        tick();
    endtask

    // Issue MFHI/MFLO and hold it while stalled, checking the bubble each cycle.
    task automatic read_hilo(input string tag, input bit is_hi);
        bit finished = 1'b0;
        for (int n = 0; n < 3 * DW && !finished; n++) begin
            set_idle();
            W_ID_valid = 1; W_ID_w_reg_ena = 1; W_ID_md_op = is_hi ? MD_MFHI : MD_MFLO;
            expect_val({tag, "_stall"}, F_STALL, 64'(md_left > 0));
            expect_val({tag, "_valid"}, F_VALID, 64'(md_left == 0));
            expect_val({tag, "_wreg"}, F_WREG, 64'(md_left == 0));
            if (md_left == 0) begin
                expect_val(tag, F_ALU, 64'(is_hi ? m_hi : m_lo));
                finished = 1'b1;
            end
            tick();
        end
        if (!finished) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    logic [3:0]    t_sel[12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                 4'd8, 4'd9, 4'd10, 4'd11};
    logic [DW-1:0] t_a[12] = '{32'h7FFF_FFFF, 32'd5, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                               32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd1, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [DW-1:0] t_b[12] = '{32'd1, 32'd7, 32'hFF00_FF00, 32'hFF00_FF00,
                               32'hFF00_FF00, 32'hFF00_FF00, 32'd1, 32'd1,
                               32'd31, 32'd4, 32'd4, 32'h0000_1234};

    initial begin
        set_idle();
        rst = 1;
        // Reset state: HI reads 0, no stall even with an md op present.
        W_ID_valid = 1; W_ID_md_op = MD_MFHI; W_ID_w_reg_ena = 1;
        expect_val("rst_busy", F_BUSY, 0);
        expect_val("rst_stall", F_STALL, 0);
        expect_val("rst_hi", F_ALU, 0);
        expect_val("rst_valid", F_VALID, 1);
        tick();
        tick();
        rst = 0;

        for (int i = 0; i < 12; i++) alu_instr($sformatf("alu%0d", i), t_sel[i], t_a[i], t_b[i]);

        // ADDI with forwarded A and sign/zero-extended immediate; rt_data keeps forwarded B.
        for (int z = 0; z < 2; z++) begin
            set_idle();
            W_ID_valid = 1; W_ID_alu_sel = ALU_ADD; W_forwardA = FWD_EX_MEM;
            W_EX_MEM_alu_res = 32'd5; W_ID_rs_data = 32'd99; W_ID_rt_sel = 1;
            W_ID_imme = 16'hFFFF; W_ID_imm_sext = (z == 0);
            W_forwardB = FWD_WB; W_WB_wb_data = 32'h1234; W_ID_rt_data = 32'h55;
            expect_val(z == 0 ? "addi_sext" : "addi_zext", F_ALU, z == 0 ? 64'd4 : 64'h10004);
            expect_val("addi_rt", F_RT, 64'h1234);
            tick();
        end
        set_idle();
        W_ID_valid = 1; W_ID_alu_sel = ALU_OR; W_forwardA = FWD_WB; W_WB_wb_data = 32'hA0;
        W_forwardB = FWD_ZERO; W_ID_rt_data = 32'hFF;
        expect_val("fwd_wb_zero", F_ALU, 64'hA0);
        expect_val("fwd_zero_rt", F_RT, 0);
        tick();

        md_start("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3);
        read_hilo("mult_hi", 1);
        read_hilo("mult_lo", 0);
        md_start("div", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        read_hilo("div_lo", 0);
        read_hilo("div_hi", 1);
        md_start("divu0", MD_DIVU, 32'd7, 32'd0);
        read_hilo("divu0_lo", 0);
        read_hilo("divu0_hi", 1);
        md_start("divmin", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        read_hilo("divmin_lo", 0);
        read_hilo("divmin_hi", 1);
        md_start("div0s", MD_DIV, 32'hFFFF_FFF0, 32'd0);
        read_hilo("div0s_lo", 0);
        read_hilo("div0s_hi", 1);
        md_start("divneg", MD_DIV, 32'd100, 32'hFFFF_FFF9);
        read_hilo("divneg_lo", 0);
        read_hilo("divneg_hi", 1);
        md_start("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_hilo("multu_hi", 1);
        read_hilo("multu_lo", 0);
        // MFLO right behind MULTU.
        md_start("multu2", MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        read_hilo("multu2_lo", 0);
        read_hilo("multu2_hi", 1);

        // ALU ops flow while busy; a second md start stalls.
        md_start("mult_b", MD_MULT, 32'd1000, 32'hFFFF_FF00);
        alu_instr("add_busy", ALU_ADD, 32'd40, 32'd2);
        alu_instr("sub_busy", ALU_SUB, 32'd40, 32'd2);
        set_idle();
        W_ID_valid = 1; W_ID_md_op = MD_DIV; W_ID_w_mem_ena = 1;
        expect_val("restart_stall", F_STALL, 1);
        expect_val("restart_wmem", F_WMEM, 0);
        tick();
        read_hilo("mult_b_lo", 0);
        read_hilo("mult_b_hi", 1);

        // Reset in the middle of a divide aborts it.
        md_start("div_abort", MD_DIV, 32'd100, 32'd7);
        for (int c = 0; c < 9; c++) idle_cycle("div_run");
        rst = 1;
        md_left = 0; start_pend = 1'b0; m_hi = '0; m_lo = '0;
        set_idle();
        W_ID_valid = 1; W_ID_md_op = MD_MFLO;
        expect_val("abort_busy", F_BUSY, 0);
        expect_val("abort_stall", F_STALL, 0);
        expect_val("abort_lo", F_ALU, 0);
        tick();
        rst = 0;
        read_hilo("post_rst_hi", 1);
        read_hilo("post_rst_lo", 0);
        md_start("mult23", MD_MULT, 32'd2, 32'd3);
        read_hilo("mult23_lo", 0);

        idle_cycle("end");
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
